// File: rtl/mysystem_wdt_kicker.sv
`timescale 1ns/1ps
// Watchdog service engine: starts an Avalon-MM watchdog timer, kicks it each interval
// while the monitored logic keeps pulsing heartbeat, and clears/counts timeout status.
module mysystem_wdt_kicker #(
  parameter logic [26:0] KICK_INTERVAL = 27'd50000000,
  parameter logic        IRQ_ENABLE    = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        heartbeat,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  output logic        running,
  output logic        starved,
  output logic [7:0]  timeout_count
);

  typedef enum logic [2:0] {
    IDLE, START_WR, WAIT_HB, KICK_WR, POLL_RD, POLL_CAP, CLR_WR
  } state_t;

  localparam logic [26:0] RELOAD = KICK_INTERVAL - 27'd1;

  state_t      state, state_nxt;
  logic [26:0] counter, counter_nxt;
  logic        hb_seen, hb_seen_nxt;
  logic        starved_nxt;
  logic        stop_req, stop_req_nxt;
  logic [7:0]  timeout_count_nxt;
  logic        resume_ok;
  logic        unused_status;

  // Only the timeout flag of the status word matters here.
  assign unused_status = ^avm_readdata[15:1];
  assign resume_ok     = enable & ~stop_req;
  assign running       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      counter       <= '0;
      hb_seen       <= 1'b0;
      starved       <= 1'b0;
      stop_req      <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      counter       <= counter_nxt;
      hb_seen       <= hb_seen_nxt;
      starved       <= starved_nxt;
      stop_req      <= stop_req_nxt;
      timeout_count <= timeout_count_nxt;
    end
  end

  // A disable seen mid-sequence is remembered so the sequence completes before IDLE.
  always_comb begin
    state_nxt         = state;
    counter_nxt       = counter;
    hb_seen_nxt       = hb_seen | (heartbeat & (state != IDLE));
    starved_nxt       = starved;
    stop_req_nxt      = stop_req | (~enable & (state inside {START_WR, KICK_WR, POLL_RD, POLL_CAP, CLR_WR}));
    timeout_count_nxt = timeout_count;
    avm_chipselect    = 1'b0;
    avm_write_n       = 1'b1;
    avm_address       = 3'd0;
    avm_writedata     = 16'h0000;

    case (state)
      IDLE: begin
        stop_req_nxt = 1'b0;
        if (enable) state_nxt = START_WR;
      end
      START_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd1;
        avm_writedata  = {13'b0, 1'b1, 1'b0, IRQ_ENABLE};
        counter_nxt    = RELOAD;
        hb_seen_nxt    = heartbeat;
        state_nxt      = resume_ok ? WAIT_HB : IDLE;
      end
      WAIT_HB: begin
        // A heartbeat on the final count cycle still earns this interval's kick.
        if (!enable) begin
          state_nxt = IDLE;
        end else if (counter == 27'd0) begin
          if (hb_seen | heartbeat) begin
            state_nxt = KICK_WR;
          end else begin
            state_nxt   = POLL_RD;
            starved_nxt = 1'b1;
          end
        end else begin
          counter_nxt = counter - 27'd1;
        end
      end
      KICK_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd2;
        hb_seen_nxt    = heartbeat;
        starved_nxt    = 1'b0;
        state_nxt      = POLL_RD;
      end
      POLL_RD: begin
        avm_chipselect = 1'b1;
        state_nxt      = POLL_CAP;
      end
      POLL_CAP: begin
        if (avm_readdata[0]) begin
          state_nxt = CLR_WR;
        end else begin
          counter_nxt = RELOAD;
          state_nxt   = resume_ok ? WAIT_HB : IDLE;
        end
      end
      CLR_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        if (timeout_count != 8'hFF) timeout_count_nxt = timeout_count + 8'd1;
        counter_nxt = RELOAD;
        state_nxt   = resume_ok ? WAIT_HB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/mysystem_wdt_kicker.md
MYSYSTEM_WDT_KICKER -- requirements
Module: mysystem_wdt_kicker

Interface
REQ-001 SHALL have parameter KICK_INTERVAL, default 27'd50000000, kick period in clk cycles; legal range 4..2^27-1.
REQ-002 SHALL have parameter IRQ_ENABLE, default 1'b0, value written to watchdog control bit 0.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  level; 1 = start and service watchdog.
REQ-006 SHALL have port heartbeat  input  1  single-cycle health pulse from monitored logic.
REQ-007 SHALL have port avm_address  output  3  Avalon-MM word address to watchdog slave.
REQ-008 SHALL have port avm_chipselect  output  1  transfer select.
REQ-009 SHALL have port avm_write_n  output  1  active-low write.
REQ-010 SHALL have port avm_writedata  output  16  write data.
REQ-011 SHALL have port avm_readdata  input  16  slave read data, registered in slave, valid one cycle after address.
REQ-012 SHALL have port running  output  1  1 when FSM is not IDLE.
REQ-013 SHALL have port starved  output  1  sticky; interval expired with no heartbeat.
REQ-014 SHALL have port timeout_count  output  8  saturating count of timeouts seen in status.

Function
REQ-015 SHALL run FSM states IDLE, START_WR, WAIT_HB, KICK_WR, POLL_RD, POLL_CAP, CLR_WR.
REQ-016 SHALL drive every bus transfer for exactly one cycle, no waitrequest; idle bus = chipselect 0, write_n 1, address 0, writedata 0.
REQ-017 IDLE: bus idle; enable=1 -> START_WR next cycle.
REQ-018 START_WR: write address 1, writedata = {13'b0, 1'b1, 1'b0, IRQ_ENABLE}; -> WAIT_HB; interval counter loaded with KICK_INTERVAL-1; hb_seen cleared.
REQ-019 WAIT_HB: counter decrements once per cycle; enable=0 -> IDLE immediately; counter==0 -> KICK_WR if hb_seen else POLL_RD with starved set.
REQ-020 KICK_WR: write address 2, writedata 16'h0000 (forces watchdog reload); starved cleared; -> POLL_RD.
REQ-021 POLL_RD: read address 0 (chipselect 1, write_n 1); -> POLL_CAP.
REQ-022 POLL_CAP: bus idle, avm_readdata sampled at end of cycle; bit0=1 -> CLR_WR, else -> WAIT_HB with counter reloaded to KICK_INTERVAL-1.
REQ-023 CLR_WR: write address 0, writedata 16'h0000; timeout_count increments, holds at 255; -> WAIT_HB, counter reloaded.
REQ-024 hb_seen SHALL be set by heartbeat in any state except IDLE, cleared on the KICK_WR cycle and at START_WR; heartbeat coincident with clear wins (hb_seen=1).
REQ-025 Heartbeat on the cycle counter==0 SHALL count for the current interval (kick issued).
REQ-026 enable falling in START_WR, KICK_WR, POLL_RD, POLL_CAP or CLR_WR SHALL let the sequence finish, then -> IDLE instead of WAIT_HB.
REQ-027 Re-enable from IDLE SHALL repeat START_WR (harmless to a running watchdog).
REQ-028 Interval SHALL be kick-to-kick: one full cycle loop = KICK_INTERVAL + 3 or +4 cycles (with CLR_WR).

Reset
REQ-029 On reset_n=0 SHALL asynchronously enter IDLE; bus idle; running 0, starved 0, timeout_count 0, hb_seen 0, counter 0.
REQ-030 Reset mid-transfer SHALL drop chipselect the same instant; no partial retry after release.
REQ-031 First transfer after reset release SHALL occur no earlier than the second rising edge with enable=1.

Verification (KICK_INTERVAL=8, IRQ_ENABLE=1, slave model returns status on next cycle)
REQ-032 enable 0->1 -> one cycle addr1 data 16'h0005, running=1 next cycle.
REQ-033 heartbeat every 5 cycles -> addr2 write each loop, addr0 read follows, starved stays 0, no CLR_WR.
REQ-034 no heartbeat for 8 cycles -> no addr2 write, starved=1, addr0 read issued; next heartbeat then kick clears starved.
REQ-035 slave readdata bit0=1 in POLL_CAP -> addr0 write data 0, timeout_count 0->1; 256 timeouts -> holds 255.
REQ-036 enable 1->0 during KICK_WR -> POLL_RD, POLL_CAP complete, then IDLE, running=0, bus idle.
REQ-037 reset_n low during POLL_RD -> chipselect 0 immediately, all outputs at reset values, IDLE after release.
